// File: rtl/tag_comparator_pkg.sv
// Shared definitions for the DRAM-cache tag comparator: FSM states,
// metadata beat layout and R-channel response decoding.
package tag_comparator_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_META = 3'd2,
        S_DATA = 3'd3,
        S_OUT  = 3'd4
    } state_e;

    // Metadata beat layout: {..., tag, dirty, valid}
    localparam int META_VALID_BIT = 0;
    localparam int META_DIRTY_BIT = 1;
    localparam int META_TAG_LSB   = 2;

    // SLVERR and DECERR both have the upper response bit set
    localparam int RRESP_ERR_BIT  = 1;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp[RRESP_ERR_BIT];
    endfunction

endpackage

// File: rtl/tag_comparator.sv
// Pops one request from the tag FIFO, consumes its two-beat tag-and-data
// response and presents one registered hit/miss record per request.
module tag_comparator
    import tag_comparator_pkg::*;
#(
    parameter int ADDR_WIDTH   = 64,
    parameter int ID_WIDTH     = 4,
    parameter int TID_WIDTH    = 16,
    parameter int INDEX_WIDTH  = 20,
    parameter int OFFSET_WIDTH = 6,
    parameter int DATA_WIDTH   = 512
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              tag_fifo_empty_i,
    output logic                              tag_fifo_rden_o,
    input  logic [ADDR_WIDTH+TID_WIDTH:0]     tag_fifo_data_i,
    input  logic [ID_WIDTH-1:0]               rid_i,
    input  logic [DATA_WIDTH-1:0]             rdata_i,
    input  logic [1:0]                        rresp_i,
    input  logic                              rlast_i,
    input  logic                              rvalid_i,
    output logic                              rready_o,
    output logic                              res_valid_o,
    input  logic                              res_ready_i,
    output logic                              res_hit_o,
    output logic                              res_write_o,
    output logic                              res_dirty_o,
    output logic [ADDR_WIDTH-INDEX_WIDTH-OFFSET_WIDTH-1:0] res_victim_tag_o,
    output logic [ADDR_WIDTH-1:0]             res_addr_o,
    output logic [TID_WIDTH-1:0]              res_tid_o,
    output logic [DATA_WIDTH-1:0]             res_data_o,
    output logic                              res_err_o
);

    localparam int TAG_WIDTH      = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
    localparam int REQ_TAG_LSB    = OFFSET_WIDTH + INDEX_WIDTH;
    localparam int FIFO_ADDR_LSB  = 0;
    localparam int FIFO_TID_LSB   = ADDR_WIDTH;
    localparam int FIFO_WRITE_BIT = ADDR_WIDTH + TID_WIDTH;

    typedef struct packed {
        logic                  hit;
        logic                  write;
        logic                  dirty;
        logic [TAG_WIDTH-1:0]  victim_tag;
        logic [ADDR_WIDTH-1:0] addr;
        logic [TID_WIDTH-1:0]  tid;
        logic [DATA_WIDTH-1:0] data;
        logic                  err;
    } result_t;

    state_e  state_r, state_s;
    result_t res_r, res_s;
    logic    meta_valid_r, meta_valid_s;
    logic    data_taken_r, data_taken_s;
    logic    rready_r;
    logic    res_valid_r;
    logic    pop_s;
    logic    rid_unused_s;

    // Next-state and result-record update, one request in flight at a time
    always_comb begin
        state_s      = state_r;
        res_s        = res_r;
        meta_valid_s = meta_valid_r;
        data_taken_s = data_taken_r;
        pop_s        = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (!tag_fifo_empty_i) begin
                    pop_s   = 1'b1;
                    state_s = S_LOAD;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_LOAD: begin
                res_s        = '0;
                res_s.write  = tag_fifo_data_i[FIFO_WRITE_BIT];
                res_s.tid    = tag_fifo_data_i[FIFO_TID_LSB +: TID_WIDTH];
                res_s.addr   = tag_fifo_data_i[FIFO_ADDR_LSB +: ADDR_WIDTH];
                meta_valid_s = 1'b0;
                data_taken_s = 1'b0;
                state_s      = S_META;
            end
            S_META: begin
                if (rvalid_i) begin
                    meta_valid_s     = rdata_i[META_VALID_BIT];
                    res_s.dirty      = rdata_i[META_DIRTY_BIT];
                    res_s.victim_tag = rdata_i[META_TAG_LSB +: TAG_WIDTH];
                    // A burst that ends on the metadata beat carries no line data
                    res_s.err        = resp_is_err(rresp_i) | rlast_i;
                    state_s          = rlast_i ? S_OUT : S_DATA;
                end else begin
                    state_s = S_META;
                end
            end
            S_DATA: begin
                if (rvalid_i) begin
                    if (!data_taken_r) begin
                        res_s.data = rdata_i;
                    end else begin
                        res_s.data = res_r.data;
                    end
                    data_taken_s = 1'b1;
                    // Overlong bursts are drained to rlast but flagged
                    res_s.err    = res_r.err | resp_is_err(rresp_i) | ~rlast_i;
                    state_s      = rlast_i ? S_OUT : S_DATA;
                end else begin
                    state_s = S_DATA;
                end
            end
            S_OUT: begin
                if (res_ready_i) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_OUT;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
        res_s.hit = meta_valid_s
                  & (res_s.victim_tag == res_s.addr[ADDR_WIDTH-1:REQ_TAG_LSB])
                  & ~res_s.err;
    end

    // State, result record and handshake registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= S_IDLE;
            res_r        <= '0;
            meta_valid_r <= 1'b0;
            data_taken_r <= 1'b0;
            rready_r     <= 1'b0;
            res_valid_r  <= 1'b0;
        end else begin
            state_r      <= state_s;
            res_r        <= res_s;
            meta_valid_r <= meta_valid_s;
            data_taken_r <= data_taken_s;
            rready_r     <= (state_s == S_META) || (state_s == S_DATA);
            res_valid_r  <= (state_s == S_OUT);
        end
    end

    // The pop is issued in the idle cycle so the entry is on the bus in S_LOAD
    assign tag_fifo_rden_o  = pop_s & rst_n;
    assign rready_o         = rready_r;
    assign res_valid_o      = res_valid_r;
    assign res_hit_o        = res_r.hit;
    assign res_write_o      = res_r.write;
    assign res_dirty_o      = res_r.dirty;
    assign res_victim_tag_o = res_r.victim_tag;
    assign res_addr_o       = res_r.addr;
    assign res_tid_o        = res_r.tid;
    assign res_data_o       = res_r.data;
    assign res_err_o        = res_r.err;

    // Responses return in order, so the ID and the low response bit carry no information here
    assign rid_unused_s = ^{rid_i, rresp_i[0]};

endmodule

// File: tb/tb_tag_comparator.sv
// Self-checking bench for tag_comparator: queue-based FIFO and R-channel
// models feed the DUT; expected records come from the hit/err rules.
module tb_tag_comparator;

    localparam int AW = 64;
    localparam int IW = 4;
    localparam int TW = 16;
    localparam int XW = 20;
    localparam int OW = 6;
    localparam int DW = 512;
    localparam int GW = AW - XW - OW;
    localparam int EW = AW + TW + 1;

    typedef struct packed {
        logic          hit;
        logic          write;
        logic          dirty;
        logic [GW-1:0] victim;
        logic [AW-1:0] addr;
        logic [TW-1:0] tid;
        logic [DW-1:0] data;
        logic          err;
    } res_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [1:0]    resp;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tag_fifo_empty_i = 1'b1;
    logic          tag_fifo_rden_o;
    logic [EW-1:0] tag_fifo_data_i = '0;
    logic [IW-1:0] rid_i = '0;
    logic [DW-1:0] rdata_i = '0;
    logic [1:0]    rresp_i = 2'b00;
    logic          rlast_i = 1'b0;
    logic          rvalid_i = 1'b0;
    logic          rready_o;
    logic          res_valid_o;
    logic          res_ready_i = 1'b1;
    logic          res_hit_o;
    logic          res_write_o;
    logic          res_dirty_o;
    logic [GW-1:0] res_victim_tag_o;
    logic [AW-1:0] res_addr_o;
    logic [TW-1:0] res_tid_o;
    logic [DW-1:0] res_data_o;
    logic          res_err_o;

    tag_comparator #(
        .ADDR_WIDTH(AW), .ID_WIDTH(IW), .TID_WIDTH(TW),
        .INDEX_WIDTH(XW), .OFFSET_WIDTH(OW), .DATA_WIDTH(DW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .tag_fifo_empty_i(tag_fifo_empty_i), .tag_fifo_rden_o(tag_fifo_rden_o),
        .tag_fifo_data_i(tag_fifo_data_i),
        .rid_i(rid_i), .rdata_i(rdata_i), .rresp_i(rresp_i), .rlast_i(rlast_i),
        .rvalid_i(rvalid_i), .rready_o(rready_o),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
        .res_hit_o(res_hit_o), .res_write_o(res_write_o), .res_dirty_o(res_dirty_o),
        .res_victim_tag_o(res_victim_tag_o), .res_addr_o(res_addr_o),
        .res_tid_o(res_tid_o), .res_data_o(res_data_o), .res_err_o(res_err_o)
    );

    always #5 clk = ~clk;

    logic [EW-1:0] fifo_q[$];
    beat_t         beat_q[$];
    res_t          exp_q[$];
    res_t          obs_q[$];
    int            rden_cyc_q[$];
    int            valid_cyc_q[$];
    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;
    bit            r_stall = 1'b0;
    bit            prev_valid = 1'b0;

    function automatic res_t dut_res();
        res_t r;
        r.hit    = res_hit_o;
        r.write  = res_write_o;
        r.dirty  = res_dirty_o;
        r.victim = res_victim_tag_o;
        r.addr   = res_addr_o;
        r.tid    = res_tid_o;
        r.data   = res_data_o;
        r.err    = res_err_o;
        return r;
    endfunction

    task automatic drive_inputs();
        tag_fifo_empty_i = (fifo_q.size() == 0);
        rid_i = 4'($urandom);
        if (beat_q.size() > 0 && !r_stall) begin
            rvalid_i = 1'b1;
            rdata_i  = beat_q[0].data;
            rresp_i  = beat_q[0].resp;
            rlast_i  = beat_q[0].last;
        end else begin
            rvalid_i = 1'b0;
            rdata_i  = {16{$urandom}};
            rresp_i  = 2'b00;
            rlast_i  = 1'b0;
        end
    endtask

    // One clock: observe at the falling edge, apply handshake effects after the rising edge
    task automatic step();
        bit f_rden, f_r;
        @(negedge clk);
        f_rden = tag_fifo_rden_o;
        f_r    = rready_o && rvalid_i;
        if (f_rden) rden_cyc_q.push_back(cyc);
        if (res_valid_o && !prev_valid) valid_cyc_q.push_back(cyc);
        prev_valid = res_valid_o;
        if (res_valid_o && res_ready_i) obs_q.push_back(dut_res());
        @(posedge clk);
        #1;
        cyc++;
        if (f_rden && fifo_q.size() > 0) tag_fifo_data_i = fifo_q.pop_front();
        if (f_r && beat_q.size() > 0) beat_q.delete(0);
        drive_inputs();
    endtask

    task automatic run_until(input int n, input int budget, input string name);
        int k = 0;
        while (obs_q.size() < n && k < budget) begin
            step();
            k++;
        end
        checks++;
        if (obs_q.size() < n) begin
            errors++;
            $display("FAIL %s_timeout got=%0d results required=%0d", name, obs_q.size(), n);
        end
    endtask

    // Queue one request and its R burst; ndata is the number of beats after the metadata beat
    task automatic add_req(input logic wr, input logic [TW-1:0] tid, input logic [AW-1:0] addr,
                           input logic valid, input logic dirty, input logic [GW-1:0] tag,
                           input logic [1:0] meta_resp, input int ndata,
                           input logic [DW-1:0] d0, input logic [1:0] data_resp);
        beat_t         b;
        res_t          e;
        logic [DW-1:0] meta;
        meta = {16{$urandom}};
        meta[0] = valid;
        meta[1] = dirty;
        meta[GW+1:2] = tag;
        fifo_q.push_back({wr, tid, addr});
        b.data = meta;
        b.resp = meta_resp;
        b.last = (ndata == 0);
        beat_q.push_back(b);
        for (int i = 0; i < ndata; i++) begin
            b.data = (i == 0) ? d0 : {16{$urandom}};
            b.resp = (i == 0) ? data_resp : 2'b00;
            b.last = (i == ndata - 1);
            beat_q.push_back(b);
        end
        e.write  = wr;
        e.tid    = tid;
        e.addr   = addr;
        e.dirty  = dirty;
        e.victim = tag;
        e.data   = (ndata > 0) ? d0 : '0;
        e.err    = meta_resp[1] || (ndata > 0 && data_resp[1]) || (ndata != 1);
        e.hit    = valid && (tag == GW'(addr >> (XW + OW))) && !e.err;
        exp_q.push_back(e);
        drive_inputs();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_inputs();
        repeat (2) @(posedge clk);
        #1;
        tag_fifo_empty_i = 1'b0;
        @(negedge clk);
        checks++;
        if ({tag_fifo_rden_o, rready_o, res_valid_o} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl got=%b required=000", {tag_fifo_rden_o, rready_o, res_valid_o});
        end
        checks++;
        if (dut_res() !== '0) begin
            errors++;
            $display("FAIL reset_fields got=%h required=0", dut_res());
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive_inputs();
    endtask

    task automatic test_read_hit();
        res_t got, exp;
        rden_cyc_q.delete();
        valid_cyc_q.delete();
        // address tag field (bits 63:26) of this address is 0x1004
        add_req(1'b0, 16'h0005, 64'h0000_0040_1234_5680, 1'b1, 1'b0, 38'h1004,
                2'b00, 1, {64{8'hA5}}, 2'b00);
        run_until(1, 40, "read_hit");
        if (obs_q.size() > 0) begin
            got = obs_q.pop_front();
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin errors++; $display("FAIL read_hit_rec got=%h exp=%h", got, exp); end
            checks++;
            if (got.hit !== 1'b1) begin errors++; $display("FAIL read_hit_hit got=%b required=1", got.hit); end
            checks++;
            if (got.tid !== 16'h0005) begin errors++; $display("FAIL read_hit_tid got=%h required=0005", got.tid); end
            checks++;
            if (got.data !== {64{8'hA5}}) begin errors++; $display("FAIL read_hit_data got=%h", got.data); end
        end
        checks++;
        if (rden_cyc_q.size() < 1 || valid_cyc_q.size() < 1 || valid_cyc_q[0] - rden_cyc_q[0] != 4) begin
            errors++;
            $display("FAIL read_hit_latency got=%0d required=4",
                     (rden_cyc_q.size() > 0 && valid_cyc_q.size() > 0) ? valid_cyc_q[0] - rden_cyc_q[0] : -1);
        end
    endtask

    task automatic test_dirty_write_miss();
        res_t got, exp;
        add_req(1'b1, 16'h0a0b, 64'h0000_0000_1123_4540, 1'b1, 1'b1, 38'h7,
                2'b00, 1, {16{$urandom}}, 2'b00);
        run_until(1, 40, "dirty_miss");
        if (obs_q.size() > 0) begin
            got = obs_q.pop_front();
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin errors++; $display("FAIL dirty_miss_rec got=%h exp=%h", got, exp); end
            checks++;
            if ({got.hit, got.dirty, got.write} !== 3'b011) begin
                errors++; $display("FAIL dirty_miss_flags got=%b required=011", {got.hit, got.dirty, got.write});
            end
            checks++;
            if (got.victim !== 38'h7) begin errors++; $display("FAIL dirty_miss_victim got=%h required=7", got.victim); end
        end
    endtask

    task automatic test_invalid_line();
        res_t got, exp;
        logic [AW-1:0] a;
        a = {$urandom, $urandom};
        add_req(1'b0, 16'h0033, a, 1'b0, 1'b0, GW'(a >> (XW + OW)), 2'b00, 1, {16{$urandom}}, 2'b00);
        run_until(1, 40, "invalid_line");
        if (obs_q.size() > 0) begin
            got = obs_q.pop_front();
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin errors++; $display("FAIL invalid_line_rec got=%h exp=%h", got, exp); end
            checks++;
            if (got.hit !== 1'b0) begin errors++; $display("FAIL invalid_line_hit got=%b required=0", got.hit); end
        end
    endtask

    task automatic test_backpressure();
        res_t got, exp, snap;
        logic [AW-1:0] a;
        int k = 0;
        int n0;
        res_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = {$urandom, $urandom};
            add_req(1'($urandom), 16'h0100 + 16'(i), a, 1'b1, 1'($urandom), GW'(a >> (XW + OW)),
                    2'b00, 1, {16{$urandom}}, 2'b00);
        end
        while (!res_valid_o && k < 40) begin step(); k++; end
        checks++;
        if (!res_valid_o) begin errors++; $display("FAIL bp_first_valid got=0 required=1"); end
        snap = dut_res();
        n0 = rden_cyc_q.size();
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (res_valid_o !== 1'b1 || dut_res() !== snap) begin
                errors++; $display("FAIL bp_stable cycle=%0d got=%h held=%h", i, dut_res(), snap);
            end
            checks++;
            if ({tag_fifo_rden_o, rready_o} !== 2'b00) begin
                errors++; $display("FAIL bp_quiet cycle=%0d got=%b required=00", i, {tag_fifo_rden_o, rready_o});
            end
        end
        checks++;
        if (rden_cyc_q.size() != n0) begin
            errors++; $display("FAIL bp_no_pop got=%0d pops required=%0d", rden_cyc_q.size(), n0);
        end
        res_ready_i = 1'b1;
        run_until(3, 100, "bp_drain");
        for (int i = 0; i < 3 && obs_q.size() > 0; i++) begin
            got = obs_q.pop_front();
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin errors++; $display("FAIL bp_drain_rec got=%h exp=%h", got, exp); end
            checks++;
            if (got.tid !== 16'h0100 + 16'(i)) begin
                errors++; $display("FAIL bp_drain_tid got=%h required=%h", got.tid, 16'h0100 + 16'(i));
            end
        end
    endtask

    task automatic test_errors();
        res_t got, exp;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        a = {$urandom, $urandom};
        add_req(1'b0, 16'h0e01, a, 1'b1, 1'b0, GW'(a >> (XW + OW)), 2'b10, 1, {16{$urandom}}, 2'b00);
        run_until(1, 40, "slverr");
        if (obs_q.size() > 0) begin
            got = obs_q.pop_front();
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin errors++; $display("FAIL slverr_rec got=%h exp=%h", got, exp); end
            checks++;
            if ({got.err, got.hit} !== 2'b10) begin errors++; $display("FAIL slverr_flags got=%b required=10", {got.err, got.hit}); end
        end
        d = {64{8'h3C}};
        add_req(1'b0, 16'h0e02, a, 1'b1, 1'b0, GW'(a >> (XW + OW)), 2'b00, 2, d, 2'b00);
        add_req(1'b0, 16'h0e03, a, 1'b1, 1'b0, GW'(a >> (XW + OW)), 2'b00, 1, {16{$urandom}}, 2'b00);
        run_until(2, 60, "long_burst");
        checks++;
        if (beat_q.size() != 0) begin errors++; $display("FAIL long_burst_drain got=%0d beats left required=0", beat_q.size()); end
        if (obs_q.size() > 1) begin
            got = obs_q.pop_front();
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin errors++; $display("FAIL long_burst_rec got=%h exp=%h", got, exp); end
            checks++;
            if (got.err !== 1'b1 || got.data !== d) begin errors++; $display("FAIL long_burst_err got=%b data=%h", got.err, got.data); end
            got = obs_q.pop_front();
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp || {got.err, got.hit} !== 2'b01) begin
                errors++; $display("FAIL after_burst_rec got=%h exp=%h", got, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        res_t got, exp;
        logic [AW-1:0] a;
        rden_cyc_q.delete();
        for (int i = 0; i < 6; i++) begin
            a = {$urandom, $urandom};
            add_req(1'($urandom), 16'hFFFD + 16'(i), a, 1'($urandom), 1'($urandom),
                    ($urandom_range(0, 1) == 1) ? GW'(a >> (XW + OW)) : GW'({$urandom, $urandom}),
                    {1'b0, 1'($urandom)}, 1, {16{$urandom}}, 2'b00);
        end
        run_until(6, 100, "b2b");
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front();
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin errors++; $display("FAIL b2b_rec got=%h exp=%h", got, exp); end
        end
        for (int i = 1; i < 6; i++) begin
            checks++;
            if (rden_cyc_q.size() <= i || rden_cyc_q[i] - rden_cyc_q[i-1] != 5) begin
                errors++;
                $display("FAIL b2b_interval idx=%0d got=%0d required=5", i,
                         (rden_cyc_q.size() > i) ? rden_cyc_q[i] - rden_cyc_q[i-1] : -1);
            end
        end
    endtask

    task automatic test_random_stall();
        res_t got, exp;
        logic [AW-1:0] a;
        int k = 0;
        for (int i = 0; i < 10; i++) begin
            a = {$urandom, $urandom};
            add_req(1'($urandom), 16'($urandom), a, 1'($urandom), 1'($urandom),
                    ($urandom_range(0, 2) != 0) ? GW'(a >> (XW + OW)) : GW'({$urandom, $urandom}),
                    ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00, $urandom_range(1, 2),
                    {16{$urandom}}, ($urandom_range(0, 7) == 0) ? 2'b11 : 2'b00);
        end
        while (obs_q.size() < 10 && k < 800) begin
            r_stall = ($urandom_range(0, 3) == 0);
            res_ready_i = ($urandom_range(0, 2) != 0);
            drive_inputs();
            step();
            k++;
        end
        r_stall = 1'b0;
        res_ready_i = 1'b1;
        drive_inputs();
        checks++;
        if (obs_q.size() < 10) begin errors++; $display("FAIL rand_timeout got=%0d results required=10", obs_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front();
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin errors++; $display("FAIL rand_rec got=%h exp=%h", got, exp); end
        end
    endtask

    task automatic test_reset_mid_burst();
        res_t got, exp;
        logic [AW-1:0] a;
        int k = 0;
        a = {$urandom, $urandom};
        add_req(1'b0, 16'h0d01, a, 1'b1, 1'b1, GW'(a >> (XW + OW)), 2'b00, 1, {16{$urandom}}, 2'b00);
        while (beat_q.size() > 1 && k < 40) begin step(); k++; end
        checks++;
        if (rready_o !== 1'b1) begin errors++; $display("FAIL mid_burst_setup got rready=%b required=1", rready_o); end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({tag_fifo_rden_o, rready_o, res_valid_o} !== 3'b000 || dut_res() !== '0) begin
            errors++;
            $display("FAIL mid_burst_reset got ctrl=%b rec=%h required 0", {tag_fifo_rden_o, rready_o, res_valid_o}, dut_res());
        end
        beat_q.delete();
        exp_q.delete();
        obs_q.delete();
        rst_n = 1'b1;
        drive_inputs();
        a = {$urandom, $urandom};
        add_req(1'b1, 16'h0d02, a, 1'b1, 1'b0, GW'(a >> (XW + OW)), 2'b00, 1, {16{$urandom}}, 2'b00);
        run_until(1, 40, "post_reset");
        if (obs_q.size() > 0) begin
            got = obs_q.pop_front();
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin errors++; $display("FAIL post_reset_rec got=%h exp=%h", got, exp); end
        end
    endtask

    initial begin
        test_reset();
        test_read_hit();
        test_dirty_write_miss();
        test_invalid_line();
        test_backpressure();
        test_errors();
        test_back_to_back();
        test_random_stall();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
